aq_vidu_vid_fpr_file: RTL and testbench
=======================================

# aq_vidu_vid_fpr_file

Parametrised floating-point architectural register file for the VIDU. It generalises the single clock-gated FP register into DEPTH entries with multiple writeback and read ports, a per-entry pending scoreboard, and NaN-boxing of single-precision results. It sits between the VPU writeback buses and the IDU operand-read/dependency-check stage.

## Interface
Parameters:
- WIDTH, 64: data width per entry; NaN-boxing requires 64.
- DEPTH, 32: number of entries; power of two.
- RD_PORTS, 3: read ports.
- WB_PORTS, 2: writeback ports.
- IDX_W, log2(DEPTH): index width, derived, not overridden.

Ports (clock and reset first):
- forever_cpuclk  in  1  free-running clock; single clock domain.
- cpurst  in  1  reset; synchronous, active-high.
- cp0_yy_clk_en  in  1  global ICG enable.
- cp0_idu_icg_en  in  1  module ICG enable.
- pad_yy_icg_scan_en  in  1  scan ICG override.
- alloc_vld  in  1  destination allocated by issue; set pending.
- alloc_idx  in  IDX_W  allocated entry.
- wb_vld  in  WB_PORTS  per-port writeback valid.
- wb_idx  in  WB_PORTS*IDX_W  per-port target entry; port p at [p*IDX_W +: IDX_W].
- wb_data  in  WB_PORTS*WIDTH  per-port data.
- wb_single  in  WB_PORTS  result is single precision; NaN-box.
- flush  in  1  pipeline flush; clears all pending bits.
- rd_idx  in  RD_PORTS*IDX_W  per-port read index.
- rd_data  out  RD_PORTS*WIDTH  per-port read data.
- rd_pending  out  RD_PORTS  read entry still awaits writeback.
- pending_vec  out  DEPTH  scoreboard, bit i = entry i pending.
- wb_conflict  out  1  registered flag: previous cycle had two valid writebacks to one entry.

## Operation
- Entry storage: per-entry gated_clk_cell, clk_in forever_cpuclk, external_en 0, global_en cp0_yy_clk_en, module_en cp0_idu_icg_en, local_en = cpurst | any wb_vld[p] with wb_idx[p]==i.
- Effective write data: wb_single[p] ? {32'hFFFF_FFFF, wb_data[p][31:0]} : wb_data[p].
- Multiple valid writebacks to the same entry in one cycle: highest-numbered port wins; wb_conflict asserts the following cycle for exactly one cycle per conflicting cycle.
- Pending bit i next state, priority high to low: cpurst -> 0; flush -> 0; alloc_vld & alloc_idx==i -> 1; any writeback to i -> 0; else hold.
- Alloc and writeback to same entry same cycle: pending ends 1 (new producer). Alloc during flush is dropped. Writebacks during flush still update data.
- Reads are combinational from rd_idx; any entry may be read by any number of ports simultaneously.
- Reset: all entries 0, pending_vec 0, wb_conflict 0, rd_pending 0 for any index; writebacks and allocs in reset cycles are ignored. Reset mid-operation discards everything at the next edge.

## Timing
- Write: data captured at the edge ending the wb_vld cycle; visible on rd_data combinationally in that same cycle only with the bypass (see Configuration), otherwise from the next cycle.
- pending_vec and wb_conflict are registered; one-cycle latency from alloc/wb/flush.
- No backpressure: every valid writeback and alloc is accepted every cycle.

## Configuration
- AQ_VIDU_FPR_BYPASS_EN defined: rd_data[r] returns the winning same-cycle effective writeback data when wb_idx matches rd_idx[r] (write-through, as the single-register block); rd_pending[r] is 0 when a same-cycle writeback hits rd_idx[r] and no alloc to that index occurs in the same cycle.
- Not defined: rd_data[r] = stored entry; rd_pending[r] = pending_vec[rd_idx[r]]; writes visible one cycle later.

## Test plan
- Reset: cpurst high 2 cycles with wb_vld=2'b11 to entries 3/5 -> all rd_data 0, pending_vec 0, wb_conflict 0 after release.
- NaN-box: wb port0 idx 7, data 64'h1234_5678_3F80_0000, wb_single=1 -> entry 7 reads 64'hFFFF_FFFF_3F80_0000; wb_single=0 -> full value stored.
- Conflict: port0 and port1 both write idx 4 (0xAA.., 0x55..) same cycle -> entry 4 = port1 data, wb_conflict high exactly next cycle.
- Scoreboard: alloc idx 9 -> pending_vec[9]=1 next cycle; alloc idx 9 plus wb idx 9 same cycle -> stays 1; wb idx 9 alone -> 0; flush with alloc idx 2 -> pending_vec all 0.
- Bypass on/off: wb idx 1 data 0xDEAD_BEEF with rd_idx[0]=1 same cycle -> with macro rd_data[0]=0xDEAD_BEEF and rd_pending[0]=0 that cycle; without macro old value that cycle, new value next cycle.
- Clock gating: cp0_idu_icg_en=1, no writes for 100 cycles -> entries hold, no gated-clock edges on idle entries.

Source files
------------

// File: rtl/aq_vidu_vid_fpr_file.sv
// ---------------------------------------------------------------------------
// aq_vidu_vid_fpr_file
// Floating-point architectural register file for the VIDU.
//   - DEPTH entries of WIDTH bits. Each entry has its own clock gate and is
//     written from WB_PORTS writeback buses. The highest-numbered valid port
//     wins when several ports target the same entry.
//   - Single-precision results are NaN-boxed: the upper bits are forced to 1.
//   - A per-entry pending scoreboard is set by alloc, cleared by writeback,
//     and cleared entirely by flush.
//   - RD_PORTS combinational read ports, each returning data and pending.
// Ports:
//   forever_cpuclk, cpurst          clock, synchronous active-high reset
//   cp0_yy_clk_en, cp0_idu_icg_en   global and module clock-gate controls
//   pad_yy_icg_scan_en              scan override that forces clocks on
//   alloc_vld/alloc_idx             destination allocation (sets pending)
//   wb_vld/wb_idx/wb_data/wb_single writeback buses
//   flush                           clears every pending bit
//   rd_idx -> rd_data/rd_pending    read ports
//   pending_vec                     registered scoreboard
//   wb_conflict                     registered same-entry writeback collision
// Optional feature macro: AQ_VIDU_FPR_BYPASS_EN. When it is defined, a
// writeback is forwarded to a read of the same entry in the same cycle.
// ---------------------------------------------------------------------------

// Clock gate cell. The enable is latched while clk_in is low, so clk_out
// cannot glitch. With module_en high, gating is active: the clock runs only
// when local_en requests it. With module_en low, the clock runs whenever
// global_en is set.
module gated_clk_cell (
  input  logic clk_in,
  input  logic external_en,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic w_en;
  logic r_en_lat;

  assign w_en = external_en | (global_en & (local_en | ~module_en));

  // The enable latch is transparent while the clock is low.
  always_latch begin
    if (!clk_in) begin
      r_en_lat <= w_en | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & r_en_lat;
endmodule

module aq_vidu_vid_fpr_file #(
  parameter  int WIDTH    = 64,
  parameter  int DEPTH    = 32,
  parameter  int RD_PORTS = 3,
  parameter  int WB_PORTS = 2,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst,
  input  logic                         cp0_yy_clk_en,
  input  logic                         cp0_idu_icg_en,
  input  logic                         pad_yy_icg_scan_en,
  input  logic                         alloc_vld,
  input  logic [IDX_W-1:0]             alloc_idx,
  input  logic [WB_PORTS-1:0]          wb_vld,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
  input  logic [WB_PORTS*WIDTH-1:0]    wb_data,
  input  logic [WB_PORTS-1:0]          wb_single,
  input  logic                         flush,
  input  logic [RD_PORTS*IDX_W-1:0]    rd_idx,
  output logic [RD_PORTS*WIDTH-1:0]    rd_data,
  output logic [RD_PORTS-1:0]          rd_pending,
  output logic [DEPTH-1:0]             pending_vec,
  output logic                         wb_conflict
);

  // Build the NaN-boxed form of a single-precision result.
  function automatic logic [WIDTH-1:0] f_nanbox(input logic [WIDTH-1:0] d,
                                                input logic             s);
    logic [WIDTH-1:0] v;
    if (s) begin
      v = {{(WIDTH-32){1'b1}}, d[31:0]};
    end else begin
      v = d;
    end
    return v;
  endfunction

  logic [DEPTH-1:0] w_hit;        // some valid writeback targets entry i
  logic [DEPTH-1:0] w_wr_en;      // hit, qualified by "not in reset"
  logic [WIDTH-1:0] w_wr_data [DEPTH];
  logic [WIDTH-1:0] w_entry   [DEPTH];
  logic [DEPTH-1:0] w_local_en;
  logic             w_conflict_nxt;
  logic [DEPTH-1:0] w_pending_nxt;
  logic [IDX_W-1:0] w_ridx    [RD_PORTS];
  logic [DEPTH-1:0] r_pending;
  logic             r_conflict;

  // Decode writebacks. Ports are scanned in ascending order, so the
  // highest-numbered valid port leaves the final value for each entry.
  always_comb begin
    w_hit          = {DEPTH{1'b0}};
    w_conflict_nxt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wr_data[i] = {WIDTH{1'b0}};
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_vld[p]) begin
        w_hit[wb_idx[p*IDX_W +: IDX_W]]     = 1'b1;
        w_wr_data[wb_idx[p*IDX_W +: IDX_W]] =
          f_nanbox(wb_data[p*WIDTH +: WIDTH], wb_single[p]);
      end else begin
        w_conflict_nxt = w_conflict_nxt;
      end
      for (int q = p + 1; q < WB_PORTS; q++) begin
        if (wb_vld[p] && wb_vld[q] &&
            (wb_idx[p*IDX_W +: IDX_W] == wb_idx[q*IDX_W +: IDX_W])) begin
          w_conflict_nxt = 1'b1;
        end else begin
          w_conflict_nxt = w_conflict_nxt;
        end
      end
    end
    w_wr_en    = w_hit & {DEPTH{~cpurst}};
    w_local_en = w_hit | {DEPTH{cpurst}};
  end

  // Entry storage. Each entry has its own gated clock. The write enable is
  // also kept on the flop, because the gate may be held open by scan or by
  // a module enable that does not gate.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic             w_gclk;
    logic [WIDTH-1:0] r_entry;

    gated_clk_cell x_gate (
      .clk_in             (forever_cpuclk),
      .external_en        (1'b0),
      .global_en          (cp0_yy_clk_en),
      .module_en          (cp0_idu_icg_en),
      .local_en           (w_local_en[gi]),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (w_gclk)
    );

    // Entry register: cleared by reset, loaded by the winning writeback.
    always_ff @(posedge w_gclk) begin
      if (cpurst) begin
        r_entry <= {WIDTH{1'b0}};
      end else if (w_wr_en[gi]) begin
        r_entry <= w_wr_data[gi];
      end else begin
        r_entry <= r_entry;
      end
    end

    assign w_entry[gi] = r_entry;
  end

  // Next scoreboard state. Flush beats alloc, and alloc beats writeback
  // clear, so a producer allocated in the same cycle as a writeback stays
  // pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (flush) begin
      w_pending_nxt = {DEPTH{1'b0}};
    end else begin
      w_pending_nxt = r_pending & ~w_hit;
      if (alloc_vld) begin
        w_pending_nxt[alloc_idx] = 1'b1;
      end else begin
        w_pending_nxt = w_pending_nxt;
      end
    end
  end

  // Scoreboard and conflict flag registers.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_pending  <= {DEPTH{1'b0}};
      r_conflict <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_conflict <= w_conflict_nxt;
    end
  end

  assign pending_vec = r_pending;
  assign wb_conflict = r_conflict;

  for (genvar gr = 0; gr < RD_PORTS; gr++) begin : g_ridx
    assign w_ridx[gr] = rd_idx[gr*IDX_W +: IDX_W];
  end

  // Combinational read ports.
  always_comb begin
    rd_data    = {(RD_PORTS*WIDTH){1'b0}};
    rd_pending = {RD_PORTS{1'b0}};
    for (int r = 0; r < RD_PORTS; r++) begin
`ifdef AQ_VIDU_FPR_BYPASS_EN
      if (w_wr_en[w_ridx[r]]) begin
        rd_data[r*WIDTH +: WIDTH] = w_wr_data[w_ridx[r]];
      end else begin
        rd_data[r*WIDTH +: WIDTH] = w_entry[w_ridx[r]];
      end
      // A same-cycle writeback retires the producer, unless a new producer
      // is allocated to the same index in this cycle.
      rd_pending[r] = r_pending[w_ridx[r]] &
                      ~(w_wr_en[w_ridx[r]] &
                        ~(alloc_vld & (alloc_idx == w_ridx[r])));
`else
      rd_data[r*WIDTH +: WIDTH] = w_entry[w_ridx[r]];
      rd_pending[r]             = r_pending[w_ridx[r]];
`endif
    end
  end

endmodule

// File: tb/tb_aq_vidu_vid_fpr_file.sv
module tb_aq_vidu_vid_fpr_file;
  localparam int W  = 64;
  localparam int D  = 32;
  localparam int RP = 3;
  localparam int WP = 2;
  localparam int IW = 5;

  logic              clk = 1'b0;
  logic              cpurst = 1'b1;
  logic              cp0_yy_clk_en = 1'b1;
  logic              cp0_idu_icg_en = 1'b1;
  logic              pad_yy_icg_scan_en = 1'b0;
  logic              alloc_vld = 1'b0;
  logic [IW-1:0]     alloc_idx = '0;
  logic [WP-1:0]     wb_vld = '0;
  logic [WP*IW-1:0]  wb_idx = '0;
  logic [WP*W-1:0]   wb_data = '0;
  logic [WP-1:0]     wb_single = '0;
  logic              flush = 1'b0;
  logic [RP*IW-1:0]  rd_idx = '0;
  logic [RP*W-1:0]   rd_data;
  logic [RP-1:0]     rd_pending;
  logic [D-1:0]      pending_vec;
  logic              wb_conflict;

  always #5 clk = ~clk;

  aq_vidu_vid_fpr_file dut (
    .forever_cpuclk     (clk),
    .cpurst             (cpurst),
    .cp0_yy_clk_en      (cp0_yy_clk_en),
    .cp0_idu_icg_en     (cp0_idu_icg_en),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .alloc_vld          (alloc_vld),
    .alloc_idx          (alloc_idx),
    .wb_vld             (wb_vld),
    .wb_idx             (wb_idx),
    .wb_data            (wb_data),
    .wb_single          (wb_single),
    .flush              (flush),
    .rd_idx             (rd_idx),
    .rd_data            (rd_data),
    .rd_pending         (rd_pending),
    .pending_vec        (pending_vec),
    .wb_conflict        (wb_conflict)
  );

  // Stimulus for the next cycle.
  logic          s_rst, s_alloc_vld, s_flush;
  logic [IW-1:0] s_alloc_idx;
  logic          s_wb_vld    [WP];
  logic [IW-1:0] s_wb_idx    [WP];
  logic [W-1:0]  s_wb_data   [WP];
  logic          s_wb_single [WP];
  logic [IW-1:0] s_rd_idx    [RP];

  // Reference model state: the architectural contents of the file.
  logic [W-1:0]  m_mem  [D];
  logic          m_pend [D];
  logic          m_conf;

  typedef struct {
    logic [W-1:0] data [RP];
    logic         pend [RP];
    logic [D-1:0] pvec;
    logic         conf;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  function automatic logic [W-1:0] nanbox(input logic [W-1:0] d, input logic s);
    return s ? {32'hFFFF_FFFF, d[31:0]} : d;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle_stim();
    s_rst = 1'b0; s_alloc_vld = 1'b0; s_flush = 1'b0; s_alloc_idx = '0;
    for (int p = 0; p < WP; p++) begin
      s_wb_vld[p] = 1'b0; s_wb_idx[p] = '0; s_wb_data[p] = '0; s_wb_single[p] = 1'b0;
    end
  endtask

  task automatic set_rd(input int a, input int b, input int c);
    s_rd_idx[0] = IW'(a); s_rd_idx[1] = IW'(b); s_rd_idx[2] = IW'(c);
  endtask

  // Apply one cycle of stimulus. Push what the DUT must show during this
  // cycle, then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    logic hit;
    @(negedge clk);
    cpurst = s_rst; alloc_vld = s_alloc_vld; alloc_idx = s_alloc_idx; flush = s_flush;
    for (int p = 0; p < WP; p++) begin
      wb_vld[p] = s_wb_vld[p];
      wb_idx[p*IW +: IW] = s_wb_idx[p];
      wb_data[p*W +: W] = s_wb_data[p];
      wb_single[p] = s_wb_single[p];
    end
    for (int r = 0; r < RP; r++) rd_idx[r*IW +: IW] = s_rd_idx[r];

    for (int r = 0; r < RP; r++) begin
      e.data[r] = m_mem[s_rd_idx[r]];
      e.pend[r] = m_pend[s_rd_idx[r]];
`ifdef AQ_VIDU_FPR_BYPASS_EN
      hit = 1'b0;
      if (!s_rst) begin
        for (int p = 0; p < WP; p++) begin
          if (s_wb_vld[p] && s_wb_idx[p] == s_rd_idx[r]) begin
            hit = 1'b1;
            e.data[r] = nanbox(s_wb_data[p], s_wb_single[p]);
          end
        end
      end
      if (hit && !(s_alloc_vld && s_alloc_idx == s_rd_idx[r])) e.pend[r] = 1'b0;
`else
      hit = 1'b0;
      e.pend[r] = e.pend[r] | hit;
`endif
    end
    for (int i = 0; i < D; i++) e.pvec[i] = m_pend[i];
    e.conf = m_conf;
    exp_q.push_back(e);

    if (s_rst) begin
      for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
      m_conf = 1'b0;
    end else begin
      m_conf = 1'b0;
      for (int p = 0; p < WP; p++)
        for (int q = p + 1; q < WP; q++)
          if (s_wb_vld[p] && s_wb_vld[q] && s_wb_idx[p] == s_wb_idx[q]) m_conf = 1'b1;
      for (int p = 0; p < WP; p++)
        if (s_wb_vld[p]) m_mem[s_wb_idx[p]] = nanbox(s_wb_data[p], s_wb_single[p]);
      if (s_flush) begin
        for (int i = 0; i < D; i++) m_pend[i] = 1'b0;
      end else begin
        for (int p = 0; p < WP; p++) if (s_wb_vld[p]) m_pend[s_wb_idx[p]] = 1'b0;
        if (s_alloc_vld) m_pend[s_alloc_idx] = 1'b1;
      end
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard in the low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int r = 0; r < RP; r++) begin
          chk($sformatf("rd_data[%0d]", r), rd_data[r*W +: W], e.data[r]);
          chk($sformatf("rd_pending[%0d]", r), {63'd0, rd_pending[r]}, {63'd0, e.pend[r]});
        end
        chk("pending_vec", {32'd0, pending_vec}, {32'd0, e.pvec});
        chk("wb_conflict", {63'd0, wb_conflict}, {63'd0, e.conf});
      end
    end
  end

  initial begin
    for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
    m_conf = 1'b0;
    idle_stim();
    set_rd(0, 0, 0);

    // Reset with writebacks to entries 3 and 5 pending in the reset cycles.
    s_rst = 1'b1;
    s_wb_vld[0] = 1'b1; s_wb_idx[0] = 5'd3; s_wb_data[0] = 64'h1111_2222_3333_4444;
    s_wb_vld[1] = 1'b1; s_wb_idx[1] = 5'd5; s_wb_data[1] = 64'h5555_6666_7777_8888;
    s_alloc_vld = 1'b1; s_alloc_idx = 5'd3;
    set_rd(3, 5, 0);
    step(); step();
    idle_stim(); step(); step();

    // NaN-boxing, first as single precision, then as double precision.
    s_wb_vld[0] = 1'b1; s_wb_idx[0] = 5'd7; s_wb_data[0] = 64'h1234_5678_3F80_0000;
    s_wb_single[0] = 1'b1; set_rd(7, 7, 0);
    step(); idle_stim(); step();
    s_wb_vld[0] = 1'b1; s_wb_idx[0] = 5'd7; s_wb_data[0] = 64'h1234_5678_3F80_0000;
    step(); idle_stim(); step();

    // Two ports write entry 4 in one cycle.
    s_wb_vld[0] = 1'b1; s_wb_idx[0] = 5'd4; s_wb_data[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    s_wb_vld[1] = 1'b1; s_wb_idx[1] = 5'd4; s_wb_data[1] = 64'h5555_5555_5555_5555;
    set_rd(4, 7, 4);
    step(); idle_stim(); step(); step();

    // Scoreboard sequence.
    set_rd(9, 2, 9);
    s_alloc_vld = 1'b1; s_alloc_idx = 5'd9; step(); idle_stim(); step();
    s_alloc_vld = 1'b1; s_alloc_idx = 5'd9;
    s_wb_vld[1] = 1'b1; s_wb_idx[1] = 5'd9; s_wb_data[1] = 64'h0F0F_0F0F_0F0F_0F0F;
    step(); idle_stim(); step();
    s_wb_vld[0] = 1'b1; s_wb_idx[0] = 5'd9; s_wb_data[0] = 64'h0123_4567_89AB_CDEF;
    step(); idle_stim(); step();
    s_alloc_vld = 1'b1; s_alloc_idx = 5'd2; step();
    s_alloc_vld = 1'b1; s_alloc_idx = 5'd9; step();
    s_flush = 1'b1; s_alloc_vld = 1'b1; s_alloc_idx = 5'd2;
    s_wb_vld[0] = 1'b1; s_wb_idx[0] = 5'd2; s_wb_data[0] = 64'hCAFE_F00D_0000_0002;
    step(); idle_stim(); step();

    // Same-cycle read of an entry being written, with a pending producer.
    s_alloc_vld = 1'b1; s_alloc_idx = 5'd1; set_rd(1, 1, 2); step(); idle_stim(); step();
    s_wb_vld[0] = 1'b1; s_wb_idx[0] = 5'd1; s_wb_data[0] = 64'h0000_0000_DEAD_BEEF;
    step(); idle_stim(); step();

    // Idle with clock gating enabled: every entry must keep its value.
    cp0_idu_icg_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      set_rd($urandom_range(0, 31), $urandom_range(0, 9), $urandom_range(0, 31));
      step();
    end

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s_rst       = ($urandom_range(0, 49) == 0);
      s_flush     = ($urandom_range(0, 15) == 0);
      s_alloc_vld = $urandom_range(0, 1) == 1;
      s_alloc_idx = IW'($urandom_range(0, 7));
      for (int p = 0; p < WP; p++) begin
        s_wb_vld[p]    = $urandom_range(0, 2) != 0;
        s_wb_idx[p]    = ($urandom_range(0, 1) == 1) ? IW'($urandom_range(0, 7))
                                                     : IW'($urandom_range(0, 31));
        s_wb_data[p]   = {$urandom, $urandom};
        s_wb_single[p] = $urandom_range(0, 1) == 1;
      end
      for (int r = 0; r < RP; r++)
        s_rd_idx[r] = ($urandom_range(0, 3) != 0) ? IW'($urandom_range(0, 7))
                                                  : IW'($urandom_range(0, 31));
      pad_yy_icg_scan_en = ($urandom_range(0, 7) == 0);
      cp0_idu_icg_en     = ($urandom_range(0, 3) != 0);
      step();
    end

    idle_stim();
    step();
    repeat (3) @(negedge clk);
    #5;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
